// File: rtl/dram_model_pkg.sv
// Shared defaults and types for the DRAM behavioural model.
// Widths here match the default 11-bit row / 10-bit column geometry.
package dram_model_pkg;

   localparam int ROW_BITS_DEF = 11;
   localparam int COL_BITS_DEF = 10;
   localparam int T_RCD_DEF    = 3;
   localparam int CAS_LAT_DEF  = 5;

   localparam logic [3:0] WE_READ = 4'hF;

   typedef struct packed {
      logic [ROW_BITS_DEF-1:0] row;
      logic [COL_BITS_DEF-1:0] col;
   } waddr_t;

endpackage

// File: rtl/dram_model_if.sv
// DRAM command/data bus between the memory controller and the DRAM.
// Strobes and byte enables are active-low.
interface dram_model_if #(
   parameter int A_W = 11
);

   logic           CSn;
   logic           RASn;
   logic           CASn;
   logic [3:0]     WEn;
   logic [A_W-1:0] A;
   logic [31:0]    D;
   logic [31:0]    Q;
   logic           VALID;

   modport master (
      output CSn, RASn, CASn, WEn, A, D,
      input  Q, VALID
   );

   modport slave (
      input  CSn, RASn, CASn, WEn, A, D,
      output Q, VALID
   );

endinterface

// File: rtl/dram_read_pipe.sv
// Fixed-latency read return path: DEPTH shift stages plus an output
// register, so data appears on the DEPTH-th edge after capture.
module dram_read_pipe #(
   parameter int DEPTH = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_vld,
   input  logic [31:0] in_data,
   output logic        out_vld,
   output logic [31:0] out_data
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [31:0]      dat_q [DEPTH];
   logic [31:0]      dat_d [DEPTH];
   logic             out_vld_q, out_vld_d;
   logic [31:0]      out_data_q, out_data_d;

   always_comb begin
      vld_d[0] = in_vld;
      dat_d[0] = in_vld ? in_data : 32'h0;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
      out_vld_d  = vld_q[DEPTH-1];
      out_data_d = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : 32'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q      <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= 32'h0;
         for (int i = 0; i < DEPTH; i++) begin
            dat_q[i] <= 32'h0;
         end
      end else begin
         vld_q      <= vld_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         for (int i = 0; i < DEPTH; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;

endmodule

// File: rtl/dram_model.sv
// Cycle-accurate 32-bit DRAM: RAS/CAS addressing, byte-lane writes,
// T_RCD gating and fixed CAS read latency.
module dram_model
   import dram_model_pkg::*;
#(
   parameter int ROW_BITS = ROW_BITS_DEF,
   parameter int COL_BITS = COL_BITS_DEF,
   parameter int T_RCD    = T_RCD_DEF,
   parameter int CAS_LAT  = CAS_LAT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   dram_model_if.slave  bus
);

   localparam int AW    = ROW_BITS + COL_BITS;
   localparam int DEPTH = 1 << AW;
   localparam int CW    = $clog2(T_RCD + 1);

   // Byte-lane storage, preloadable hierarchically; never reset.
   logic [7:0] mem [4][DEPTH];

   logic                row_open_q, row_open_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [CW-1:0]       rcd_q, rcd_d;

   logic                act;
   logic                cas_ok;
   logic                rd_en;
   logic [COL_BITS-1:0] col;
   logic [AW-1:0]       waddr;
   logic [31:0]         rd_word;
   logic                pipe_vld;
   logic [31:0]         pipe_data;

   always_comb begin
      col    = bus.A[COL_BITS-1:0];
      waddr  = {row_q, col};
      act    = !bus.CSn && !bus.RASn && !row_open_q;
      cas_ok = !bus.CSn && !bus.RASn && !bus.CASn &&
               row_open_q && (rcd_q >= CW'(T_RCD));
      rd_en  = cas_ok && (bus.WEn == WE_READ);
      for (int i = 0; i < 4; i++) begin
         rd_word[8*i +: 8] = mem[i][waddr];
      end
   end

   // rcd counts edges since activate and saturates at T_RCD.
   always_comb begin
      row_open_d = row_open_q;
      row_d      = row_q;
      rcd_d      = rcd_q;
      if (bus.RASn) begin
         row_open_d = 1'b0;
         rcd_d      = '0;
      end else if (act) begin
         row_open_d = 1'b1;
         row_d      = bus.A[ROW_BITS-1:0];
         rcd_d      = CW'(1);
      end else if (row_open_q && (rcd_q < CW'(T_RCD))) begin
         rcd_d = rcd_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_open_q <= 1'b0;
         row_q      <= '0;
         rcd_q      <= '0;
      end else begin
         row_open_q <= row_open_d;
         row_q      <= row_d;
         rcd_q      <= rcd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (cas_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (!bus.WEn[i]) begin
               mem[i][waddr] <= bus.D[8*i +: 8];
            end
         end
      end
   end

   dram_read_pipe #(
      .DEPTH (CAS_LAT)
   ) u_read_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (rd_en),
      .in_data  (rd_word),
      .out_vld  (pipe_vld),
      .out_data (pipe_data)
   );

   assign bus.VALID = pipe_vld;
   assign bus.Q     = pipe_data;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && !bus.CASn && !cas_ok) begin
         $display("dram_model: warning, CAS ignored at %0t", $time);
      end
   end
`endif

endmodule

// File: tb/tb_dram_model.sv
// Scoreboard bench for dram_model: directed scenarios then random
// commands against a cycle-numbered behavioural model.
module tb_dram_model;
   import dram_model_pkg::*;

   localparam int TRCD = 3;
   localparam int CL   = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dram_model_if #(.A_W(ROW_BITS_DEF)) bus();

   dram_model dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl [int];
   bit          open_m = 1'b0;
   int          row_m  = 0;
   int          act_m  = 0;

   int total = 0;
   int bad   = 0;
   bit fin   = 1'b0;
   int fin_cyc = 0;

   task automatic preload(int row, int col, logic [31:0] w);
      waddr_t wa;
      wa.row = row[ROW_BITS_DEF-1:0];
      wa.col = col[COL_BITS_DEF-1:0];
      for (int l = 0; l < 4; l++) begin
         dut.mem[l][wa] = w[8*l +: 8];
      end
      mdl[int'(wa)] = w;
   endtask

   // Drive one command, predict its effect at the coming edge, then step.
   task automatic cmd(bit csn, bit rasn, bit casn, logic [3:0] wen,
                      int a, logic [31:0] d);
      int          e;
      waddr_t      wa;
      logic [31:0] w;
      e        = cyc + 1;
      bus.CSn  = csn;
      bus.RASn = rasn;
      bus.CASn = casn;
      bus.WEn  = wen;
      bus.A    = 11'(a);
      bus.D    = d;
      if (rasn) begin
         open_m = 1'b0;
      end else if (!csn && !open_m) begin
         open_m = 1'b1;
         row_m  = a;
         act_m  = e;
      end else if (!csn && !casn && open_m && (e - act_m >= TRCD)) begin
         wa.row = row_m[ROW_BITS_DEF-1:0];
         wa.col = a[COL_BITS_DEF-1:0];
         w = mdl[int'(wa)];
         if (wen == WE_READ) begin
            exp_q.push_back('{e + CL, w});
         end else begin
            for (int l = 0; l < 4; l++) begin
               if (!wen[l]) w[8*l +: 8] = d[8*l +: 8];
            end
            mdl[int'(wa)] = w;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic act(int row);
      cmd(1'b0, 1'b0, 1'b1, WE_READ, row, 32'h0);
   endtask

   task automatic nop();
      cmd(1'b0, 1'b0, 1'b1, WE_READ, 0, 32'h0);
   endtask

   task automatic rd(int col);
      cmd(1'b0, 1'b0, 1'b0, WE_READ, col, 32'h0);
   endtask

   task automatic wr(int col, logic [3:0] wen, logic [31:0] d);
      cmd(1'b0, 1'b0, 1'b0, wen, col, d);
   endtask

   task automatic pre();
      cmd(1'b1, 1'b1, 1'b1, WE_READ, 0, 32'h0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL read_latency: no VALID at cycle %0d, required at cycle %0d with Q=%h",
                     cyc, exp_q[0].due, exp_q[0].data);
            void'(exp_q.pop_front());
         end
         total++;
         if (bus.VALID) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL spurious_valid: VALID=1 Q=%h at cycle %0d, required VALID=0",
                        bus.Q, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.due != cyc || bus.Q !== e.data) begin
                  bad++;
                  $display("FAIL read_data: Q=%h at cycle %0d, required Q=%h at cycle %0d",
                           bus.Q, cyc, e.data, e.due);
               end
            end
         end else if (bus.Q !== 32'h0) begin
            bad++;
            $display("FAIL idle_q: Q=%h with VALID=0 at cycle %0d, required 0",
                     bus.Q, cyc);
         end
         if (fin && (exp_q.size() == 0 || cyc > fin_cyc + 40)) begin
            if (exp_q.size() != 0) begin
               total++;
               bad++;
               $display("FAIL drain_timeout: %0d reads pending, required 0",
                        exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

   initial begin
      bus.CSn  = 1'b1;
      bus.RASn = 1'b1;
      bus.CASn = 1'b1;
      bus.WEn  = WE_READ;
      bus.A    = '0;
      bus.D    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Read in flight when reset hits must never return
      preload(0, 0, 32'h11223344);
      act(0);
      nop();
      nop();
      rd(0);
      nop();
      nop();
      rst = 1'b1;
      exp_q.delete();
      open_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) pre();

      preload(3, 5, 32'hDEADBEEF);
      act(3);
      nop();
      nop();
      rd(5);
      repeat (6) nop();

      preload(3, 6, 32'h00000000);
      wr(6, 4'b1010, 32'hAABBCCDD);
      rd(6);
      repeat (6) nop();

      for (int i = 0; i < 4; i++) preload(3, i, 32'(i + 1));
      for (int i = 0; i < 4; i++) rd(i);
      repeat (6) nop();

      // CAS too early after activate: write and read both dropped
      pre();
      act(3);
      wr(6, 4'b0000, 32'hFFFFFFFF);
      rd(6);
      rd(6);
      repeat (6) nop();

      pre();
      preload(7, 0, 32'hCAFEF00D);
      act(7);
      nop();
      nop();
      rd(0);
      cmd(1'b0, 1'b1, 1'b0, WE_READ, 0, 32'h0);
      act(7);
      nop();
      nop();
      cmd(1'b1, 1'b0, 1'b0, WE_READ, 0, 32'h0);
      rd(0);
      repeat (8) pre();

      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) preload(r, c, $urandom);
      end
      for (int n = 0; n < 400; n++) begin
         cmd(($urandom % 8) == 0,
             ($urandom % 12) == 0,
             1'($urandom % 2),
             ($urandom % 2) ? WE_READ : 4'($urandom),
             $urandom_range(0, 7),
             $urandom);
      end
      pre();
      fin_cyc = cyc;
      fin = 1'b1;
   end

endmodule

// File: doc/dram_model.md
Name: dram_model

Overview:
- Cycle-accurate behavioural model of an off-chip 32-bit DRAM.
- Used at testbench level as the external main-memory target of the SoC's DRAM controller.
- Provides multiplexed row/column addressing (RASn/CASn), per-byte write enables and a fixed CAS read latency.
- Reports read data with a single-cycle VALID strobe.

Parameters:
- ROW_BITS, 11, row address width sampled from A on activate.
- COL_BITS, 10, column address width taken from A[COL_BITS-1:0] on CAS.
- T_RCD, 3, minimum cycles from activate to first accepted CAS.
- CAS_LAT, 5, cycles from read CAS edge to VALID.

Ports:
- clk  in  1  clock; all commands are sampled on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- CSn  in  1  chip select, active-low; when high, all commands are ignored.
- RASn  in  1  row strobe, active-low; a row is open while this is low.
- CASn  in  1  column strobe, active-low; one access per cycle it is sampled low.
- WEn  in  4  byte write enables, active-low; 4'hF means read; bit i controls byte lane i.
- A  in  11  multiplexed row/column address.
- D  in  32  write data.
- Q  out  32  read data.
- VALID  out  1  Q valid, one-cycle pulse per read.

Behaviour:
- Storage:
  - Four byte-lane arrays, each of depth 2^(ROW_BITS+COL_BITS), with word index = {row, col}.
  - The arrays are hierarchically accessible so the bench can preload them with $readmemh.
  - Reset does not clear storage; contents are X unless preloaded.
- Reset:
  - Q=0, VALID=0.
  - Row closed, T_RCD counter cleared.
  - Read pipeline flushed; reads in flight when reset asserts are discarded and never produce VALID.
- Activate:
  - Occurs on an edge with CSn=0 and RASn=0 while no row is open.
  - Latches row=A[ROW_BITS-1:0], marks the row open and starts the T_RCD counter.
- Precharge:
  - Occurs on any edge with RASn=1; closes the row.
  - CSn is not required for precharge.
- Column access:
  - Conditions: edge with CSn=0, RASn=0, CASn=0, row open, and at least T_RCD edges since activate.
  - col=A[COL_BITS-1:0].
  - The activate edge itself never counts as a CAS, even if CASn is low on that edge.
- Write (WEn!=4'hF):
  - Each lane i with WEn[i]=0 gets D[8i+7:8i]; other lanes are untouched.
  - Takes effect at the CAS edge; no VALID is generated.
- Read (WEn=4'hF):
  - Word is captured at the CAS edge and enters a CAS_LAT-deep pipeline.
  - Q/VALID are updated on the CAS_LAT-th rising edge after the CAS edge.
  - VALID is high for exactly one cycle; Q=0 whenever VALID=0.
  - Back-to-back CAS on consecutive cycles yields consecutive VALID pulses in issue order.
- Read-after-write hazard: a read to a word written in an earlier cycle returns the new data.
- Ignored commands:
  - CAS with the row closed, CAS before T_RCD has elapsed, or CAS with CSn=1.
  - An ignored CAS causes no write and no VALID, and issues a $display warning (simulation only).
- Precharge with reads in flight: the pipeline keeps draining and all pending reads still complete.
- Row change: a new row requires a precharge (RASn high for at least one edge) followed by a new activate.

Decomposition:
- Package dram_model_pkg:
  - Default ROW_BITS/COL_BITS/T_RCD/CAS_LAT.
  - Typedef for the word address {row, col}.
  - Localparam for the read code (4'hF).
- Sub-module dram_read_pipe: CAS_LAT-stage valid/data shift register with async clear.
- Top level holds the storage, command decode, row register and T_RCD counter.

Test Plan:
- Reset mid-read: preload word 0 = 32'h11223344; activate row 0 then CAS read col 0; assert rst 2 cycles later -> VALID never asserts, Q=0.
- Basic read latency: preload word {row 3, col 5} = 32'hDEADBEEF; activate row 3; wait T_RCD; read col 5 -> VALID high exactly 5 cycles later for 1 cycle with Q=DEADBEEF.
- Byte write: word = 32'h00000000; write WEn=4'b1010, D=32'hAABBCCDD; then read -> Q=32'h00BB00DD.
- Burst reads: reads to cols 0,1,2,3 on consecutive cycles (values 1,2,3,4) -> 4 consecutive VALID cycles returning 1,2,3,4.
- Timing violation: CAS 1 cycle after activate -> no VALID, no write; retry after T_RCD succeeds.
- Row switch: precharge, activate row 7, read col 0 -> data from row 7; CAS while RASn=1 -> ignored.
